// File: rtl/scr1_dmi_ch_dr.sv
// scr1_dmi_ch_dr: core-clock DTM data-register stage.
// Holds the DTMCS (channel id 1) and DMI access (channel id 2) scan registers.
// Converts a completed DMI update into a request/response transaction toward the
// Debug Module.
//
// Ports:
//   clk, rst        core clock, synchronous active-high reset
//   ch_sel_i        DMI channel selected by the TAP IR
//   ch_id_i         1 = DTMCS, 2 = DMI, others = no register
//   ch_capture_i    one-cycle capture strobe
//   ch_shift_i      one-cycle shift strobe
//   ch_update_i     one-cycle update strobe
//   ch_tdi_i        serial data in
//   ch_tdo_o        serial data out (LSB flop of the selected register)
//   dmi_req_o       request valid
//   dmi_wr_o        request is a write
//   dmi_addr_o      request address
//   dmi_wdata_o     request write data
//   dmi_req_ack_i   DM accepted the request
//   dmi_resp_i      DM response valid (one cycle)
//   dmi_resp_err_i  response failed
//   dmi_rdata_i     response read data
//
// Optional macro SCR1_DMI_REQ_TIMEOUT_EN adds a WAIT_RESP timeout counter
// that gives up after TIMEOUT_CYCLES cycles and reports dmistat=2.
module scr1_dmi_ch_dr #(
   parameter int unsigned ABITS          = 7,
   parameter int unsigned IDLE_HINT      = 1,
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ch_sel_i,
   input  logic [1:0]       ch_id_i,
   input  logic             ch_capture_i,
   input  logic             ch_shift_i,
   input  logic             ch_update_i,
   input  logic             ch_tdi_i,
   output logic             ch_tdo_o,
   output logic             dmi_req_o,
   output logic             dmi_wr_o,
   output logic [ABITS-1:0] dmi_addr_o,
   output logic [31:0]      dmi_wdata_o,
   input  logic             dmi_req_ack_i,
   input  logic             dmi_resp_i,
   input  logic             dmi_resp_err_i,
   input  logic [31:0]      dmi_rdata_i
);

   localparam int unsigned DMI_W   = ABITS + 34;
   localparam int unsigned DTMCS_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic               req_q, req_d;
   logic               wr_q, wr_d;
   logic [ABITS-1:0]   addr_q, addr_d;
   logic [31:0]        wdata_q, wdata_d;
   logic [31:0]        rdata_q, rdata_d;
   logic [1:0]         sticky_q, sticky_d;
   logic [DTMCS_W-1:0] dtmcs_sr_q, dtmcs_sr_d;
   logic [DMI_W-1:0]   dmi_sr_q, dmi_sr_d;

   logic               sel_dtmcs;
   logic               sel_dmi;
   logic               busy;
   logic               complete;
   logic [1:0]         cap_op;
   logic [1:0]         upd_op;

`ifdef SCR1_DMI_REQ_TIMEOUT_EN
   localparam int unsigned CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned CNT_W   = (CNT_RAW < 8) ? 8 : ((CNT_RAW > 32) ? 32 : CNT_RAW);
   logic [CNT_W-1:0] cnt_q, cnt_d;
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT_CYCLES == 32'd0);
`endif

   assign sel_dtmcs = ch_sel_i && (ch_id_i == 2'd1);
   assign sel_dmi   = ch_sel_i && (ch_id_i == 2'd2);
   assign busy      = (state_q != ST_IDLE);

   // Serial output is the LSB flop of whichever register is selected.
   assign ch_tdo_o = sel_dtmcs ? dtmcs_sr_q[0] : (sel_dmi ? dmi_sr_q[0] : 1'b0);

   assign dmi_req_o   = req_q;
   assign dmi_wr_o    = wr_q;
   assign dmi_addr_o  = addr_q;
   assign dmi_wdata_o = wdata_q;

   // Next-state, transaction tracking and scan-register behaviour.
   always_comb begin
      state_d    = state_q;
      req_d      = req_q;
      wr_d       = wr_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      sticky_d   = sticky_q;
      dtmcs_sr_d = dtmcs_sr_q;
      dmi_sr_d   = dmi_sr_q;
      complete   = 1'b0;
      cap_op     = 2'd0;
      upd_op     = dmi_sr_q[1:0];
`ifdef SCR1_DMI_REQ_TIMEOUT_EN
      cnt_d      = (state_q == ST_WAIT) ? cnt_q + CNT_W'(1) : '0;
`endif

      case (state_q)
         ST_REQ: begin
            if (dmi_req_ack_i) begin
               req_d = 1'b0;
               if (dmi_resp_i) begin
                  complete = 1'b1;
                  state_d  = ST_IDLE;
               end else begin
                  state_d  = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (dmi_resp_i) begin
               complete = 1'b1;
               state_d  = ST_IDLE;
            end
`ifdef SCR1_DMI_REQ_TIMEOUT_EN
            else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               state_d = ST_IDLE;
               if (sticky_d == 2'd0) sticky_d = 2'd2;
            end
`endif
         end
         default: ;
      endcase

      // Completion is applied before any strobe so a same-cycle dmireset wins.
      if (complete) begin
         if (dmi_resp_err_i) begin
            if (sticky_d == 2'd0) sticky_d = 2'd2;
         end else if (!wr_q) begin
            rdata_d = dmi_rdata_i;
         end
      end

      // DTMCS register
      if (sel_dtmcs) begin
         if (ch_capture_i) begin
            dtmcs_sr_d = {14'b0, 1'b0, 1'b0, 1'b0, 3'(IDLE_HINT), sticky_q, 6'(ABITS), 4'd1};
         end else if (ch_shift_i) begin
            dtmcs_sr_d = {ch_tdi_i, dtmcs_sr_q[DTMCS_W-1:1]};
         end else if (ch_update_i) begin
            if (dtmcs_sr_q[16]) sticky_d = 2'd0;
            if (dtmcs_sr_q[17]) begin
               sticky_d = 2'd0;
               state_d  = ST_IDLE;
               req_d    = 1'b0;
            end
         end
      end

      // DMI access register
      if (sel_dmi) begin
         if (ch_capture_i) begin
            if (sticky_q != 2'd0) cap_op = sticky_q;
            else if (busy)        cap_op = 2'd3;
            dmi_sr_d = {addr_q, rdata_q, cap_op};
            if (busy && (sticky_d == 2'd0)) sticky_d = 2'd3;
         end else if (ch_shift_i) begin
            dmi_sr_d = {ch_tdi_i, dmi_sr_q[DMI_W-1:1]};
         end else if (ch_update_i) begin
            if (busy || (sticky_q != 2'd0)) begin
               // Dropped request; only a busy collision raises a new error.
               if (busy && (sticky_d == 2'd0)) sticky_d = 2'd3;
            end else if ((upd_op == 2'd1) || (upd_op == 2'd2)) begin
               addr_d  = dmi_sr_q[DMI_W-1:34];
               wdata_d = dmi_sr_q[33:2];
               wr_d    = (upd_op == 2'd2);
               req_d   = 1'b1;
               state_d = ST_REQ;
            end
         end
      end
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         req_q      <= 1'b0;
         wr_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         sticky_q   <= 2'd0;
         dtmcs_sr_q <= '0;
         dmi_sr_q   <= '0;
`ifdef SCR1_DMI_REQ_TIMEOUT_EN
         cnt_q      <= '0;
`endif
      end else begin
         state_q    <= state_d;
         req_q      <= req_d;
         wr_q       <= wr_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         rdata_q    <= rdata_d;
         sticky_q   <= sticky_d;
         dtmcs_sr_q <= dtmcs_sr_d;
         dmi_sr_q   <= dmi_sr_d;
`ifdef SCR1_DMI_REQ_TIMEOUT_EN
         cnt_q      <= cnt_d;
`endif
      end
   end

endmodule

// File: tb/tb_scr1_dmi_ch_dr.sv
// Testbench for scr1_dmi_ch_dr: directed scans with a transaction-level model
// (sticky status, outstanding flag, latched request fields, last read data).
module tb_scr1_dmi_ch_dr;

   localparam int unsigned ABITS     = 7;
   localparam int unsigned IDLE_HINT = 1;
   localparam int unsigned TO_CYC    = 16;
   localparam int unsigned W         = ABITS + 34;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             ch_sel = 1'b0;
   logic [1:0]       ch_id = 2'd0;
   logic             ch_capture = 1'b0;
   logic             ch_shift = 1'b0;
   logic             ch_update = 1'b0;
   logic             ch_tdi = 1'b0;
   logic             ch_tdo;
   logic             dmi_req;
   logic             dmi_wr;
   logic [ABITS-1:0] dmi_addr;
   logic [31:0]      dmi_wdata;
   logic             dmi_req_ack = 1'b0;
   logic             dmi_resp = 1'b0;
   logic             dmi_resp_err = 1'b0;
   logic [31:0]      dmi_rdata = 32'h0;

   int errors = 0;
   int checks = 0;

   // Transaction-level model state
   bit               m_run = 1'b0;
   bit               m_req = 1'b0;
   bit               m_wr = 1'b0;
   bit               m_busy = 1'b0;
   logic [6:0]       m_addr = 7'h0;
   logic [31:0]      m_wdata = 32'h0;
   logic [31:0]      m_rdata = 32'h0;
   logic [1:0]       m_sticky = 2'd0;
   bit               m_tdo = 1'b0;
   bit               m_tdo_chk = 1'b0;

   logic [40:0]      cap;

   scr1_dmi_ch_dr #(
      .ABITS(ABITS), .IDLE_HINT(IDLE_HINT), .TIMEOUT_CYCLES(TO_CYC)
   ) dut (
      .clk(clk), .rst(rst),
      .ch_sel_i(ch_sel), .ch_id_i(ch_id),
      .ch_capture_i(ch_capture), .ch_shift_i(ch_shift), .ch_update_i(ch_update),
      .ch_tdi_i(ch_tdi), .ch_tdo_o(ch_tdo),
      .dmi_req_o(dmi_req), .dmi_wr_o(dmi_wr), .dmi_addr_o(dmi_addr), .dmi_wdata_o(dmi_wdata),
      .dmi_req_ack_i(dmi_req_ack), .dmi_resp_i(dmi_resp),
      .dmi_resp_err_i(dmi_resp_err), .dmi_rdata_i(dmi_rdata)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (m_run) begin
         check("req", 64'(dmi_req), 64'(m_req));
         check("wr", 64'(dmi_wr), 64'(m_wr));
         check("addr", 64'(dmi_addr), 64'(m_addr));
         check("wdata", 64'(dmi_wdata), 64'(m_wdata));
         if (m_tdo_chk) check("tdo", 64'(ch_tdo), 64'(m_tdo));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_n(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   function automatic logic [40:0] dmi_word(input logic [6:0] a, input logic [31:0] d,
                                            input logic [1:0] op);
      return {a, d, op};
   endfunction

   // Value the model says a capture of register id must load.
   function automatic logic [40:0] cap_val(input logic [1:0] id);
      logic [1:0]  op;
      logic [31:0] v;
      if (id == 2'd1) begin
         v = 32'd1 + (32'(ABITS) << 4) + (32'(m_sticky) << 10) + (32'(IDLE_HINT) << 12);
         return 41'(v);
      end
      op = (m_sticky != 2'd0) ? m_sticky : (m_busy ? 2'd3 : 2'd0);
      return {m_addr, m_rdata, op};
   endfunction

   task automatic strobe(input logic [1:0] id, input bit c, input bit s, input bit u, input bit d);
      ch_sel = 1'b1; ch_id = id;
      ch_capture = c; ch_shift = s; ch_update = u; ch_tdi = d;
      tick();
      ch_capture = 1'b0; ch_shift = 1'b0; ch_update = 1'b0;
   endtask

   task automatic model_update(input logic [1:0] id, input logic [40:0] din);
      logic [1:0] op;
      if (id == 2'd1) begin
         if (din[16] || din[17]) m_sticky = 2'd0;
         if (din[17]) begin m_busy = 1'b0; m_req = 1'b0; end
      end else begin
         op = din[1:0];
         if (m_busy || m_sticky != 2'd0) begin
            if (m_busy && m_sticky == 2'd0) m_sticky = 2'd3;
         end else if (op == 2'd1 || op == 2'd2) begin
            m_addr = din[40:34]; m_wdata = din[33:2];
            m_wr = (op == 2'd2); m_req = 1'b1; m_busy = 1'b1;
         end
      end
   endtask

   task automatic model_complete(input bit err, input logic [31:0] rd);
      m_busy = 1'b0;
      if (err) begin
         if (m_sticky == 2'd0) m_sticky = 2'd2;
      end else if (!m_wr) begin
         m_rdata = rd;
      end
   endtask

   // Full capture / shift / update pass; returns the shifted-out stream.
   task automatic scan(input logic [1:0] id, input logic [40:0] din, output logic [40:0] cout);
      int          len;
      logic [40:0] exp;
      len  = (id == 2'd1) ? 32 : int'(W);
      exp  = cap_val(id);
      cout = '0;
      strobe(id, 1'b1, 1'b0, 1'b0, 1'b0);
      if (id == 2'd2 && m_busy && m_sticky == 2'd0) m_sticky = 2'd3;
      m_tdo = exp[0]; m_tdo_chk = 1'b1;
      for (int i = 0; i < len; i++) begin
         cout[i] = ch_tdo;
         strobe(id, 1'b0, 1'b1, 1'b0, din[i]);
         m_tdo = (i + 1 < len) ? exp[i+1] : din[0];
      end
      strobe(id, 1'b0, 1'b0, 1'b1, 1'b0);
      model_update(id, din);
      m_tdo_chk = 1'b0;
      ch_sel = 1'b0;
   endtask

   task automatic dm_ack(input bit with_resp, input bit err, input logic [31:0] rd);
      dmi_req_ack = 1'b1; dmi_resp = with_resp; dmi_resp_err = err; dmi_rdata = rd;
      tick();
      dmi_req_ack = 1'b0; dmi_resp = 1'b0; dmi_resp_err = 1'b0;
      m_req = 1'b0;
      if (with_resp) model_complete(err, rd);
   endtask

   task automatic dm_resp(input bit err, input logic [31:0] rd);
      dmi_resp = 1'b1; dmi_resp_err = err; dmi_rdata = rd;
      tick();
      dmi_resp = 1'b0; dmi_resp_err = 1'b0;
      model_complete(err, rd);
   endtask

   initial begin
      // Reset
      wait_n(3);
      check("rst_req", 64'(dmi_req), 64'd0);
      check("rst_tdo", 64'(ch_tdo), 64'd0);
      check("rst_addr", 64'(dmi_addr), 64'd0);
      check("rst_wdata", 64'(dmi_wdata), 64'd0);
      rst = 1'b0;
      tick();
      m_run = 1'b1;

      // DTMCS capture stream
      scan(2'd1, 41'd0, cap);
      check("dtmcs_reset", 64'(cap[31:0]), 64'h0000_1071);

      // Read: ack after 2 cycles, response one cycle later
      scan(2'd2, dmi_word(7'h10, 32'h0, 2'd1), cap);
      check("rd_req_lat", 64'(dmi_req), 64'd1);
      check("rd_wr", 64'(dmi_wr), 64'd0);
      check("rd_addr", 64'(dmi_addr), 64'h10);
      wait_n(2);
      dm_ack(1'b0, 1'b0, 32'h0);
      wait_n(1);
      dm_resp(1'b0, 32'hDEAD_BEEF);
      wait_n(2);
      scan(2'd2, 41'd0, cap);
      check("rd_capture", 64'(cap), 64'({7'h10, 32'hDEAD_BEEF, 2'd0}));

      // Write with ack and response in the same cycle
      scan(2'd2, dmi_word(7'h17, 32'h8000_0001, 2'd2), cap);
      check("wr_wr", 64'(dmi_wr), 64'd1);
      check("wr_wdata", 64'(dmi_wdata), 64'h8000_0001);
      dm_ack(1'b1, 1'b0, 32'h1111_2222);
      scan(2'd2, 41'd0, cap);
      check("wr_capture", 64'(cap), 64'({7'h17, 32'hDEAD_BEEF, 2'd0}));

      // Update while waiting for a response is dropped
      scan(2'd2, dmi_word(7'h05, 32'h0, 2'd1), cap);
      dm_ack(1'b0, 1'b0, 32'h0);
      scan(2'd2, dmi_word(7'h06, 32'h0, 2'd1), cap);
      check("busy_op", 64'(cap[1:0]), 64'd3);
      check("busy_noreq", 64'(dmi_req), 64'd0);
      dm_resp(1'b0, 32'h1234_5678);
      scan(2'd2, dmi_word(7'h08, 32'h0, 2'd1), cap);
      check("sticky_op", 64'(cap[1:0]), 64'd3);
      check("sticky_noreq", 64'(dmi_req), 64'd0);
      scan(2'd1, 41'(1 << 16), cap);
      check("dtmcs_busy", 64'(cap[31:0]), 64'h0000_1C71);
      scan(2'd2, dmi_word(7'h22, 32'h0, 2'd1), cap);
      check("after_clr_capture", 64'(cap), 64'({7'h05, 32'h1234_5678, 2'd0}));
      check("after_clr_req", 64'(dmi_req), 64'd1);
      wait_n(1);
      dm_ack(1'b1, 1'b0, 32'hCAFE_F00D);

      // Error response
      scan(2'd2, dmi_word(7'h30, 32'h0, 2'd1), cap);
      dm_ack(1'b0, 1'b0, 32'h0);
      wait_n(2);
      dm_resp(1'b1, 32'h5555_5555);
      scan(2'd2, 41'd0, cap);
      check("err_capture", 64'(cap), 64'({7'h30, 32'hCAFE_F00D, 2'd2}));
      scan(2'd1, 41'(1 << 16), cap);
      check("dtmcs_err", 64'(cap[31:0]), 64'h0000_1871);

      // dmihardreset during REQ
      scan(2'd2, dmi_word(7'h31, 32'h0, 2'd1), cap);
      wait_n(3);
      scan(2'd1, 41'(1 << 17), cap);
      check("hard_req", 64'(dmi_req), 64'd0);
      wait_n(2);
      scan(2'd2, dmi_word(7'h0A, 32'hA5A5_0001, 2'd2), cap);
      check("hard_capture", 64'(cap), 64'({7'h31, 32'hCAFE_F00D, 2'd0}));
      dm_ack(1'b0, 1'b0, 32'h0);
      dm_resp(1'b0, 32'h0BAD_0BAD);
      scan(2'd2, 41'd0, cap);
      check("post_hard_capture", 64'(cap), 64'({7'h0A, 32'hCAFE_F00D, 2'd0}));

`ifdef SCR1_DMI_REQ_TIMEOUT_EN
      // No response: give up after TO_CYC cycles, late response ignored
      scan(2'd2, dmi_word(7'h40, 32'h0, 2'd1), cap);
      dm_ack(1'b0, 1'b0, 32'h0);
      wait_n(int'(TO_CYC));
      m_busy = 1'b0;
      m_sticky = 2'd2;
      wait_n(3);
      dmi_resp = 1'b1; dmi_rdata = 32'h7777_7777;
      tick();
      dmi_resp = 1'b0;
      scan(2'd2, 41'd0, cap);
      check("timeout_capture", 64'(cap), 64'({7'h40, 32'hCAFE_F00D, 2'd2}));
`endif

      wait_n(2);
      m_run = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
